// File: rtl/latch_bank_writer.sv
// latch_bank_writer: writes one word per valid/ready handshake into a bank of D latches
// using a registered setup / enable-pulse / hold sequence. Macro LATCH_BANK_WRITER_VERIFY_EN adds read-back checking.
module latch_bank_writer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SETUP = 1,
  parameter int unsigned PULSE = 2,
  parameter int unsigned HOLD  = 1,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] lat_d,
  output logic [DEPTH-1:0] lat_e,
  output logic             busy,
  output logic             done
`ifdef LATCH_BANK_WRITER_VERIFY_EN
  ,
  input  logic [WIDTH-1:0] lat_q,
  output logic             err
`endif
);

  localparam int unsigned MAX_LEN = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                                    : ((PULSE > HOLD) ? PULSE : HOLD);
  localparam int unsigned CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0] lat_e_q, lat_e_d;
  logic             done_q, done_d;
  logic             accept, phase_end, in_range;

  assign wr_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = wr_valid && wr_ready;
  assign phase_end = (cnt_q == '0);
  // Addresses beyond DEPTH still run the full sequence but never raise an enable.
  assign in_range  = (32'(addr_q) < DEPTH);

  // NOTE: async reset on every register, so lat_e and lat_d clear the moment rst rises, even mid-pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch inferred).
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(PULSE - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PULSE: begin
        if (phase_end) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (phase_end) state_d = ST_IDLE;
        else           cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, keeping lat_e glitch-free.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    lat_e_d = '0;
    if (accept) begin
      addr_d = wr_addr;
      data_d = wr_data;
    end
    if (state_d == ST_PULSE && in_range) lat_e_d = DEPTH'(1) << addr_q;
    done_d = (state_q == ST_HOLD) && phase_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      lat_e_q <= '0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      lat_e_q <= lat_e_d;
      done_q  <= done_d;
    end
  end

  assign lat_d = data_q;
  assign lat_e = lat_e_q;
  assign done  = done_q;

`ifdef LATCH_BANK_WRITER_VERIFY_EN
  logic err_q, err_d;

  // Read-back is compared in the last HOLD cycle, after the latch has closed.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_HOLD && phase_end && in_range && (lat_q != data_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_latch_bank_writer.sv
// tb_latch_bank_writer: table vectors, corner-case sequences and a random run against a
// transaction-level model; a DEPTH=4 and a DEPTH=3 instance share the same stimulus.
module tb_latch_bank_writer;
  localparam int S = 1, P = 2, H = 1, N = S + P + H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       ready4, busy4, done4, ready3, busy3, done3;
  logic [7:0] lat_d4, lat_d3;
  logic [3:0] lat_e4;
  logic [2:0] lat_e3;
  logic       force_bad = 1'b0;

  always #5 clk = ~clk;

`ifdef LATCH_BANK_WRITER_VERIFY_EN
  logic [7:0] mem4 [4];
  logic [7:0] mem3 [3];
  logic [7:0] lat_q4, lat_q3;
  logic       err4, err3;
`endif

  latch_bank_writer #(.WIDTH(8), .DEPTH(4), .SETUP(S), .PULSE(P), .HOLD(H)) u_dut4 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready4), .wr_addr(wr_addr),
    .wr_data(wr_data), .lat_d(lat_d4), .lat_e(lat_e4), .busy(busy4), .done(done4)
`ifdef LATCH_BANK_WRITER_VERIFY_EN
    , .lat_q(lat_q4), .err(err4)
`endif
  );

  latch_bank_writer #(.WIDTH(8), .DEPTH(3), .SETUP(S), .PULSE(P), .HOLD(H)) u_dut3 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready3), .wr_addr(wr_addr),
    .wr_data(wr_data), .lat_d(lat_d3), .lat_e(lat_e3), .busy(busy3), .done(done3)
`ifdef LATCH_BANK_WRITER_VERIFY_EN
    , .lat_q(lat_q3), .err(err3)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction model: k counts cycles since the accept (0 = idle).
  int         k;
  logic [1:0] m_addr;
  logic [7:0] m_data;
  logic       m_done;
  logic       m_err [2];

`ifdef LATCH_BANK_WRITER_VERIFY_EN
  for (genvar g = 0; g < 4; g++) begin : g_lat4
    always_latch if (lat_e4[g]) mem4[g] <= lat_d4;
  end
  for (genvar g = 0; g < 3; g++) begin : g_lat3
    always_latch if (lat_e3[g]) mem3[g] <= lat_d3;
  end
  assign lat_q4 = force_bad ? 8'h00 : mem4[m_addr];
  assign lat_q3 = force_bad ? 8'h00 : ((m_addr < 2'd3) ? mem3[m_addr] : 8'h00);
`endif

  function automatic logic [3:0] exp_e(input int depth);
    logic [3:0] one = 4'b0001;
    if (k > S && k <= S + P && int'(m_addr) < depth) return one << m_addr;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    k = 0; m_addr = '0; m_data = '0; m_done = 1'b0;
    m_err[0] = 1'b0; m_err[1] = 1'b0;
  endtask

  task automatic model_step();
    if (k == N) begin
      if (force_bad && m_data != 8'h00) m_err[0] = 1'b1;
      if (force_bad && m_data != 8'h00 && m_addr < 2'd3) m_err[1] = 1'b1;
    end
    m_done = (k == N);
    if (k == 0) begin
      if (wr_valid) begin
        k = 1; m_addr = wr_addr; m_data = wr_data;
      end
    end else if (k == N) k = 0;
    else k++;
  endtask

  task automatic cmp_model();
    check("ready4", ready4, k == 0);
    check("busy4",  busy4,  k != 0);
    check("done4",  done4,  m_done);
    check("lat_d4", lat_d4, m_data);
    check("lat_e4", lat_e4, exp_e(4));
    check("ready3", ready3, k == 0);
    check("done3",  done3,  m_done);
    check("lat_d3", lat_d3, m_data);
    check("lat_e3", lat_e3, exp_e(3));
`ifdef LATCH_BANK_WRITER_VERIFY_EN
    check("err4", err4, m_err[0]);
    check("err3", err3, m_err[1]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst lat_e4", lat_e4, 4'b0000);
    check("rst lat_d4", lat_d4, 8'h00);
    check("rst ready4", ready4, 1'b1);
    check("rst busy4",  busy4,  1'b0);
    check("rst done4",  done4,  1'b0);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] a;
    logic [7:0] d;
    logic [3:0] e;
    logic [7:0] ld;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t tbl [6];

  // Row i: inputs during cycle i, outputs expected in cycle i+1 (write addr 2, data A5).
  task automatic run_table();
    for (int i = 0; i < 6; i++) begin
      wr_valid = tbl[i].v; wr_addr = tbl[i].a; wr_data = tbl[i].d;
      tick();
      check($sformatf("tbl%0d lat_e", i), lat_e4, tbl[i].e);
      check($sformatf("tbl%0d lat_d", i), lat_d4, tbl[i].ld);
      check($sformatf("tbl%0d done", i),  done4,  tbl[i].dn);
      check($sformatf("tbl%0d ready", i), ready4, tbl[i].rdy);
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd2, 8'hA5, 4'b0000, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 2'd0, 8'h00, 4'b0100, 8'hA5, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 2'd0, 8'h00, 4'b0100, 8'hA5, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'hA5, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'hA5, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'hA5, 1'b0, 1'b1};
    model_reset();

    #2;
    do_reset();
    run_table();

    // Back-to-back: second accept in cycle 5, enables in cycles 2-3 and 7-8.
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 8'h11;
    for (int c = 1; c <= 10; c++) begin
      logic [3:0] e_exp;
      tick();
      if (c == 1) begin wr_addr = 2'd3; wr_data = 8'h3C; end
      if (c == 6) wr_valid = 1'b0;
      e_exp = (c == 2 || c == 3) ? 4'b0001 : (c == 7 || c == 8) ? 4'b1000 : 4'b0000;
      check($sformatf("b2b c%0d lat_e", c), lat_e4, e_exp);
      if (c == 5) check("b2b c5 ready", ready4, 1'b1);
    end

    // Requests presented while busy are ignored.
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h77;
    tick();
    wr_addr = 2'd2; wr_data = 8'h99;
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 3) wr_valid = 1'b0;
      check($sformatf("busy c%0d lat_d", c), lat_d4, 8'h77);
      check($sformatf("busy c%0d lat_e", c), lat_e4, (c == 2 || c == 3) ? 4'b0010 : 4'b0000);
    end

    // Reset in the middle of the enable pulse.
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5;
    tick();
    wr_valid = 1'b0;
    tick();
    check("pre-rst lat_e4", lat_e4, 4'b0100);
    #2;
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    run_table();

    // Out-of-range address on the DEPTH=3 instance.
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 8'hFF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      wr_valid = 1'b0;
      check($sformatf("oor c%0d lat_e3", c), lat_e3, 3'b000);
      check($sformatf("oor c%0d done3", c),  done3,  c == 5);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 8'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < N + 2; i++) tick();

`ifdef LATCH_BANK_WRITER_VERIFY_EN
    force_bad = 1'b1;
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h5A;
    for (int c = 1; c <= 9; c++) begin
      tick();
      wr_valid = 1'b0;
      check($sformatf("verify c%0d err4", c), err4, c >= 5);
    end
    force_bad = 1'b0;
    do_reset();
    check("verify err4 cleared", err4, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
